pc_unit: RTL



---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_unit_if.sv | 35 +++
 rtl/pc_unit_branch_lut.sv | 31 +++
 rtl/pc_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter stage
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int          PC_W_DEF   = 10;
  localparam int          LUT_AW_DEF = 5;
  localparam logic [15:0] CYCLE_MAX  = 16'hFFFF;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control, LUT-write and address bundle of the PC stage
interface pc_unit_if import pc_pkg::*; #(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
);

  logic              start;
  logic              stall;
  logic              halt_req;
  logic              jump_en;
  logic              branch_en;
  logic              alu_zero;
  logic [LUT_AW-1:0] lut_idx;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              instr_valid;
  logic              branch_taken;
  logic              done;
  logic [15:0]       cycle_count;

  modport master (
    output start, stall, halt_req, jump_en, branch_en, alu_zero,
    output lut_idx, lut_we, lut_waddr, lut_wdata,
    input  pc, instr_valid, branch_taken, done, cycle_count
  );

  modport slave (
    input  start, stall, halt_req, jump_en, branch_en, alu_zero,
    input  lut_idx, lut_we, lut_waddr, lut_wdata,
    output pc, instr_valid, branch_taken, done, cycle_count
  );

endinterface

// File: rtl/pc_unit_branch_lut.sv
// rtl/pc_unit_branch_lut.sv - absolute branch/jump target table, 1W 1R-async
module branch_lut import pc_pkg::*; #(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [LUT_AW-1:0] i_waddr,
  input  logic [PC_W-1:0]   i_wdata,
  input  logic [LUT_AW-1:0] i_raddr,
  output logic [PC_W-1:0]   o_rdata
);

  logic [PC_W-1:0] r_mem [2**LUT_AW];

  // Table storage: cleared by reset, written whenever the write enable is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**LUT_AW; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read straight from the stored array, so a same-edge write is not seen yet
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter, next-address mux, run/halt FSM and cycle counter
module pc_unit import pc_pkg::*; #(
  parameter int PC_W       = PC_W_DEF,
  parameter int LUT_AW     = LUT_AW_DEF,
  parameter int START_ADDR = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.slave bus
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  pc_state_t       r_state;
  pc_state_t       w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_target;
  logic            r_instr_valid;
  logic            r_branch_taken;
  logic            r_done;
  logic            w_taken;
  logic [15:0]     r_cycle_count;
  logic [15:0]     w_cc_nxt;

  branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (bus.lut_we),
    .i_waddr (bus.lut_waddr),
    .i_wdata (bus.lut_wdata),
    .i_raddr (bus.lut_idx),
    .o_rdata (w_target)
  );

  // Next state, next PC and counter; a stalled RUN cycle leaves everything as is
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_taken     = 1'b0;
    w_cc_nxt    = r_cycle_count;
    case (r_state)
      IDLE, HALT: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = START_PC;
          w_cc_nxt    = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          w_cc_nxt = (r_cycle_count == CYCLE_MAX) ? r_cycle_count : r_cycle_count + 16'd1;
          if (bus.halt_req) begin
            w_state_nxt = HALT;
          end else if (bus.jump_en || (bus.branch_en && bus.alu_zero)) begin
            w_pc_nxt = w_target;
            w_taken  = 1'b1;
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; valid/done decode the next state so they move with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pc           <= START_PC;
      r_instr_valid  <= 1'b0;
      r_branch_taken <= 1'b0;
      r_done         <= 1'b0;
      r_cycle_count  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_instr_valid  <= (w_state_nxt == RUN);
      r_branch_taken <= w_taken;
      r_done         <= (w_state_nxt == HALT);
      r_cycle_count  <= w_cc_nxt;
    end
  end

  assign bus.pc           = r_pc;
  assign bus.instr_valid  = r_instr_valid;
  assign bus.branch_taken = r_branch_taken;
  assign bus.done         = r_done;
  assign bus.cycle_count  = r_cycle_count;

endmodule
